// File: rtl/gray_stream_checker.sv
// rtl/gray_stream_checker.sv - Gray stream decoder and step classifier with saturating error count
module gray_stream_checker #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clr_err,
    output logic             out_valid,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_up,
    output logic             step_down,
    output logic             step_hold,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count,
    output logic             sticky_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] prev_bin;
    logic [WIDTH-1:0] cur_bin;
    logic [WIDTH-1:0] diff;
    logic             is_hold;
    logic             is_single;

    logic [WIDTH-1:0] prev_gray_nxt;
    logic [WIDTH-1:0] bin_nxt;
    logic             valid_nxt;
    logic             up_nxt;
    logic             down_nxt;
    logic             hold_nxt;
    logic             err_nxt;
    logic [ERR_W-1:0] count_nxt;
    logic             sticky_nxt;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Hamming distance classes: zero bits, exactly one bit (power of two), or more
    always_comb begin
        cur_bin   = gray2bin(gray_in);
        prev_bin  = gray2bin(prev_gray);
        diff      = gray_in ^ prev_gray;
        is_hold   = (diff == '0);
        is_single = !is_hold && ((diff & (diff - WIDTH'(1))) == '0);
    end

    // State register; history is discarded on reset so the next sample is a first sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next registered outputs; flags default low so they only show with out_valid
    always_comb begin
        state_nxt     = state;
        prev_gray_nxt = prev_gray;
        bin_nxt       = bin_out;
        valid_nxt     = 1'b0;
        up_nxt        = 1'b0;
        down_nxt      = 1'b0;
        hold_nxt      = 1'b0;
        err_nxt       = 1'b0;
        count_nxt     = err_count;
        sticky_nxt    = sticky_err;

        if (clr_err) begin
            count_nxt  = '0;
            sticky_nxt = 1'b0;
        end

        if (in_valid) begin
            prev_gray_nxt = gray_in;
            bin_nxt       = cur_bin;
            valid_nxt     = 1'b1;
            case (state)
                EMPTY: begin
                    state_nxt = TRACK;
                end
                TRACK: begin
                    if (is_hold) begin
                        hold_nxt = 1'b1;
                    end else if (is_single) begin
                        // Modular add makes max->0 an up-step and 0->max a down-step
                        if (cur_bin == prev_bin + WIDTH'(1)) begin
                            up_nxt = 1'b1;
                        end else begin
                            down_nxt = 1'b1;
                        end
                    end else begin
                        err_nxt    = 1'b1;
                        sticky_nxt = 1'b1;
                        // A clear arriving with an error still records that error
                        if (clr_err) begin
                            count_nxt = ERR_W'(1);
                        end else if (!(&err_count)) begin
                            count_nxt = err_count + ERR_W'(1);
                        end
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Registered datapath and outputs, one cycle behind the accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_gray  <= '0;
            bin_out    <= '0;
            out_valid  <= 1'b0;
            step_up    <= 1'b0;
            step_down  <= 1'b0;
            step_hold  <= 1'b0;
            step_err   <= 1'b0;
            err_count  <= '0;
            sticky_err <= 1'b0;
        end else begin
            prev_gray  <= prev_gray_nxt;
            bin_out    <= bin_nxt;
            out_valid  <= valid_nxt;
            step_up    <= up_nxt;
            step_down  <= down_nxt;
            step_hold  <= hold_nxt;
            step_err   <= err_nxt;
            err_count  <= count_nxt;
            sticky_err <= sticky_nxt;
        end
    end

endmodule

// File: tb/tb_gray_stream_checker.sv
// tb/tb_gray_stream_checker.sv - directed self-checking bench for gray_stream_checker
module tb_gray_stream_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] gray_in;
    logic       clr_err;

    logic       out_valid, step_up, step_down, step_hold, step_err, sticky_err;
    logic [3:0] bin_out;
    logic [7:0] err_count;

    logic       out_valid2, step_up2, step_down2, step_hold2, step_err2, sticky_err2;
    logic [3:0] bin_out2;
    logic [1:0] err_count2;

    int errors = 0;
    int checks = 0;

    gray_stream_checker #(.WIDTH(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in), .clr_err(clr_err),
        .out_valid(out_valid), .bin_out(bin_out), .step_up(step_up), .step_down(step_down),
        .step_hold(step_hold), .step_err(step_err), .err_count(err_count), .sticky_err(sticky_err)
    );

    gray_stream_checker #(.WIDTH(4), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray_in(gray_in), .clr_err(clr_err),
        .out_valid(out_valid2), .bin_out(bin_out2), .step_up(step_up2), .step_down(step_down2),
        .step_hold(step_hold2), .step_err(step_err2), .err_count(err_count2), .sticky_err(sticky_err2)
    );

    always #5 clk = ~clk;

    // Flag vector order: {out_valid, step_up, step_down, step_hold, step_err}
    localparam logic [4:0] F_NONE  = 5'b00000;
    localparam logic [4:0] F_FIRST = 5'b10000;
    localparam logic [4:0] F_UP    = 5'b11000;
    localparam logic [4:0] F_DOWN  = 5'b10100;
    localparam logic [4:0] F_HOLD  = 5'b10010;
    localparam logic [4:0] F_ERR   = 5'b10001;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] f, input logic [3:0] b,
                           input logic [7:0] cnt, input logic st);
        chk({tag, "/flags"}, 32'({out_valid, step_up, step_down, step_hold, step_err}), 32'(f));
        chk({tag, "/bin"}, 32'(bin_out), 32'(b));
        chk({tag, "/cnt"}, 32'(err_count), 32'(cnt));
        chk({tag, "/sticky"}, 32'(sticky_err), 32'(st));
    endtask

    // Apply inputs for one edge, then settle 1 time unit past the edge
    task automatic drive(input logic v, input logic [3:0] g, input logic c);
        in_valid = v;
        gray_in  = g;
        clr_err  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 4'b0000, 1'b0);
        rst = 1'b0;
    endtask

    logic [3:0] g07 [8];

    initial begin
        g07 = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100};
        rst = 1'b1; in_valid = 1'b0; gray_in = '0; clr_err = 1'b0;
        #1;
        chk_all("reset_async", F_NONE, 4'd0, 8'd0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        drive(1'b0, 4'b0000, 1'b0);
        rst = 1'b0;
        chk_all("reset", F_NONE, 4'd0, 8'd0, 1'b0);

        // Count 0..7: first sample has no flags, then up-steps
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, g07[i], 1'b0);
            chk_all($sformatf("count%0d", i), (i == 0) ? F_FIRST : F_UP, 4'(i), 8'd0, 1'b0);
        end

        // Wrap-around in both directions, starting from a fresh history
        do_reset();
        drive(1'b1, 4'b1000, 1'b0); chk_all("wrap_first", F_FIRST, 4'd15, 8'd0, 1'b0);
        drive(1'b1, 4'b0000, 1'b0); chk_all("wrap_up",    F_UP,    4'd0,  8'd0, 1'b0);
        drive(1'b1, 4'b1000, 1'b0); chk_all("wrap_down",  F_DOWN,  4'd15, 8'd0, 1'b0);

        // Hold then a two-bit jump
        do_reset();
        drive(1'b1, 4'b0011, 1'b0); chk_all("hold_first", F_FIRST, 4'd2, 8'd0, 1'b0);
        drive(1'b1, 4'b0011, 1'b0); chk_all("hold",       F_HOLD,  4'd2, 8'd0, 1'b0);
        drive(1'b1, 4'b0101, 1'b0); chk_all("jump2",      F_ERR,   4'd6, 8'd1, 1'b1);

        // clr_err coinciding with a three-bit jump keeps the new error
        drive(1'b1, 4'b0000, 1'b0); chk_all("jump_to0",   F_ERR,   4'd0, 8'd2, 1'b1);
        drive(1'b1, 4'b0111, 1'b1); chk_all("clr_with_err", F_ERR, 4'd5, 8'd1, 1'b1);
        drive(1'b0, 4'b0000, 1'b1); chk_all("clr_alone",  F_NONE,  4'd5, 8'd0, 1'b0);
        chk("sat/clr", 32'(err_count2), 32'd0);

        // Five illegal jumps: 8-bit counter climbs, 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i % 2 == 0) ? 4'b0000 : 4'b0111, 1'b0);
            chk_all($sformatf("jump%0d", i), F_ERR, (i % 2 == 0) ? 4'd0 : 4'd5, 8'(i + 1), 1'b1);
            chk($sformatf("sat%0d", i), 32'(err_count2), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // Gaps between samples: no out_valid, bin_out holds, classification unchanged
        drive(1'b1, 4'b0001, 1'b0); chk_all("gap_s1",  F_UP,   4'd1, 8'd5, 1'b1);
        drive(1'b0, 4'b1111, 1'b0); chk_all("gap_a",   F_NONE, 4'd1, 8'd5, 1'b1);
        drive(1'b0, 4'b1010, 1'b0); chk_all("gap_b",   F_NONE, 4'd1, 8'd5, 1'b1);
        drive(1'b1, 4'b0011, 1'b0); chk_all("gap_s2",  F_UP,   4'd2, 8'd5, 1'b1);
        drive(1'b0, 4'b0000, 1'b0); chk_all("gap_c",   F_NONE, 4'd2, 8'd5, 1'b1);
        drive(1'b1, 4'b0011, 1'b0); chk_all("gap_hold", F_HOLD, 4'd2, 8'd5, 1'b1);
        drive(1'b0, 4'b0000, 1'b0); chk_all("gap_d",   F_NONE, 4'd2, 8'd5, 1'b1);
        drive(1'b1, 4'b0001, 1'b0); chk_all("gap_down", F_DOWN, 4'd1, 8'd5, 1'b1);

        // Climb to bin 5, then reset between edges
        drive(1'b1, 4'b0011, 1'b0); chk_all("mid_2", F_UP, 4'd2, 8'd5, 1'b1);
        drive(1'b1, 4'b0010, 1'b0); chk_all("mid_3", F_UP, 4'd3, 8'd5, 1'b1);
        drive(1'b1, 4'b0110, 1'b0); chk_all("mid_4", F_UP, 4'd4, 8'd5, 1'b1);
        drive(1'b1, 4'b0111, 1'b0); chk_all("mid_5", F_UP, 4'd5, 8'd5, 1'b1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", F_NONE, 4'd0, 8'd0, 1'b0);
        chk("async_rst/sat", 32'(err_count2), 32'd0);
        #1 rst = 1'b0;
        drive(1'b1, 4'b0111, 1'b0); chk_all("after_rst", F_FIRST, 4'd5, 8'd0, 1'b0);
        drive(1'b1, 4'b0101, 1'b0); chk_all("after_rst_up", F_UP, 4'd6, 8'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
